// File: rtl/vga_sync_gen_if.sv
// Video timing bundle: pixel enable in, sync/active/coordinate/pulse outputs.
interface vga_sync_gen_if #(
  parameter int unsigned CW = 10
);
  logic          en;
  logic          hsync;
  logic          vsync;
  logic          active;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          line_start;
  logic          frame_start;

  // Timing generator side.
  modport master (
    input  en,
    output hsync, vsync, active, x, y, line_start, frame_start
  );

  // Consumer side (pattern generators, pin drivers).
  modport slave (
    output en,
    input  hsync, vsync, active, x, y, line_start, frame_start
  );
endinterface

// File: rtl/vga_sync_gen.sv
// Pixel-domain video timing generator: raster counters with registered decode.
// Outputs are decoded from the next counter values so every output describes
// exactly the (x,y) currently presented on x/y.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_sync_gen_if.master vif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEGIN = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEGIN = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] hc;
  logic [CW-1:0] vc;
  logic [CW-1:0] hc_nxt;
  logic [CW-1:0] vc_nxt;
  logic          hs_on_nxt;
  logic          vs_on_nxt;
  logic          active_nxt;
  logic          line_nxt;
  logic          frame_nxt;

  logic          hsync_q;
  logic          vsync_q;
  logic          active_q;
  logic          line_start_q;
  logic          frame_start_q;

  // Next raster position: wrap x at end of line, bump y only on that wrap.
  always_comb begin
    hc_nxt = hc;
    vc_nxt = vc;
    if (hc == H_LAST) begin
      hc_nxt = '0;
      if (vc == V_LAST) begin
        vc_nxt = '0;
      end else begin
        vc_nxt = vc + CW'(1);
      end
    end else begin
      hc_nxt = hc + CW'(1);
    end
  end

  // Decode the position about to be presented.
  always_comb begin
    hs_on_nxt  = (hc_nxt >= HS_BEGIN) && (hc_nxt < HS_END);
    vs_on_nxt  = (vc_nxt >= VS_BEGIN) && (vc_nxt < VS_END);
    active_nxt = (hc_nxt < H_VIS) && (vc_nxt < V_VIS);
    line_nxt   = (hc_nxt == '0);
    frame_nxt  = (hc_nxt == '0) && (vc_nxt == '0);
  end

  // Counters: park on the last position so the first enabled pixel is (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc <= H_LAST;
      vc <= V_LAST;
    end else if (vif.en) begin
      hc <= hc_nxt;
      vc <= vc_nxt;
    end
  end

  // Level outputs hold while en is low; sync levels are polarity-adjusted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      active_q <= 1'b0;
    end else if (vif.en) begin
      hsync_q  <= hs_on_nxt ^ ~HS_POL;
      vsync_q  <= vs_on_nxt ^ ~VS_POL;
      active_q <= active_nxt;
    end
  end

  // Pulse outputs last one clock and are cleared on any cycle without en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= vif.en & line_nxt;
      frame_start_q <= vif.en & frame_nxt;
    end
  end

  assign vif.x           = hc;
  assign vif.y           = vc;
  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.active      = active_q;
  assign vif.line_start  = line_start_q;
  assign vif.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (default 640x480, a tiny raster,
// and an active-high-sync raster) checked against an arithmetic raster model.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  vga_sync_gen_if #(.CW(10)) vif_d ();
  vga_sync_gen_if #(.CW(6))  vif_a ();
  vga_sync_gen_if #(.CW(9))  vif_b ();

  vga_sync_gen u_d (.clk(clk), .rst_n(rst_n), .vif(vif_d));

  vga_sync_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .CW(6)
  ) u_a (.clk(clk), .rst_n(rst_n), .vif(vif_a));

  vga_sync_gen #(
    .H_ACTIVE(320), .H_FP(8), .H_SYNC(48), .H_BP(24),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(9)
  ) u_b (.clk(clk), .rst_n(rst_n), .vif(vif_b));

  // Vector layout: {hsync, vsync, active, line_start, frame_start, x[9:0], y[9:0]}
  int          n_d, n_a, n_b;
  logic [24:0] exp_d, exp_a, exp_b;

  // Raster model: after n enabled pixels the position is pixel (n-1) of an
  // endless frame sequence; n=0 is the reset state.
  function automatic logic [24:0] calc(input int n, input int ha, input int hfp,
                                       input int hs, input int hbp, input int va,
                                       input int vfp, input int vs, input int vbp,
                                       input bit hp, input bit vp);
    int ht, vt, p, px, py;
    bit h_on, v_on;
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    if (n == 0) return {~hp, ~vp, 3'b000, 10'(ht - 1), 10'(vt - 1)};
    p  = (n - 1) % (ht * vt);
    px = p % ht;
    py = p / ht;
    h_on = (px >= ha + hfp) && (px < ha + hfp + hs);
    v_on = (py >= va + vfp) && (py < va + vfp + vs);
    return {(h_on ? hp : ~hp), (v_on ? vp : ~vp), ((px < ha) && (py < va)),
            (px == 0), ((px == 0) && (py == 0)), 10'(px), 10'(py)};
  endfunction

  function automatic logic [24:0] model_d(input int n);
    return calc(n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
  endfunction
  function automatic logic [24:0] model_a(input int n);
    return calc(n, 16, 2, 3, 4, 10, 2, 2, 3, 1'b0, 1'b0);
  endfunction
  function automatic logic [24:0] model_b(input int n);
    return calc(n, 320, 8, 48, 24, 6, 1, 1, 2, 1'b1, 1'b1);
  endfunction

  function automatic logic [24:0] obs_d();
    return {vif_d.hsync, vif_d.vsync, vif_d.active, vif_d.line_start,
            vif_d.frame_start, 10'(vif_d.x), 10'(vif_d.y)};
  endfunction
  function automatic logic [24:0] obs_a();
    return {vif_a.hsync, vif_a.vsync, vif_a.active, vif_a.line_start,
            vif_a.frame_start, 10'(vif_a.x), 10'(vif_a.y)};
  endfunction
  function automatic logic [24:0] obs_b();
    return {vif_b.hsync, vif_b.vsync, vif_b.active, vif_b.line_start,
            vif_b.frame_start, 10'(vif_b.x), 10'(vif_b.y)};
  endfunction

  task automatic reset_models();
    n_d = 0; n_a = 0; n_b = 0;
    exp_d = model_d(0); exp_a = model_a(0); exp_b = model_b(0);
  endtask

  // One clock with the given enables; the model advances or freezes to match.
  task automatic tick(input bit ed, input bit ea, input bit eb);
    vif_d.en = ed; vif_a.en = ea; vif_b.en = eb;
    @(posedge clk);
    #1;
    if (ed) begin n_d++; exp_d = model_d(n_d); end else exp_d[21:20] = 2'b00;
    if (ea) begin n_a++; exp_a = model_a(n_a); end else exp_a[21:20] = 2'b00;
    if (eb) begin n_b++; exp_b = model_b(n_b); end else exp_b[21:20] = 2'b00;
  endtask

  task automatic test_reset();
    logic [24:0] first_px;
    rst_n = 1'b0;
    vif_d.en = 1'b0; vif_a.en = 1'b0; vif_b.en = 1'b0;
    reset_models();
    repeat (3) @(posedge clk);
    #1;
    total++; if (obs_d() !== exp_d) begin bad++; $display("FAIL reset_d: got %h want %h", obs_d(), exp_d); end
    total++; if (obs_a() !== exp_a) begin bad++; $display("FAIL reset_a: got %h want %h", obs_a(), exp_a); end
    total++; if (obs_b() !== exp_b) begin bad++; $display("FAIL reset_b: got %h want %h", obs_b(), exp_b); end
    total++; if ({vif_b.hsync, vif_b.vsync} !== 2'b00) begin
      bad++; $display("FAIL reset_b_sync_level: got %b want 00", {vif_b.hsync, vif_b.vsync});
    end
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    total++; if (obs_d() !== exp_d) begin bad++; $display("FAIL idle_after_release_d: got %h want %h", obs_d(), exp_d); end
    tick(1'b1, 1'b1, 1'b1);
    first_px = {5'b11111, 20'd0};
    total++; if (obs_d() !== first_px) begin bad++; $display("FAIL first_pixel_d: got %h want %h", obs_d(), first_px); end
    total++; if (obs_a() !== exp_a) begin bad++; $display("FAIL first_pixel_a: got %h want %h", obs_a(), exp_a); end
    total++; if (obs_b() !== exp_b) begin bad++; $display("FAIL first_pixel_b: got %h want %h", obs_b(), exp_b); end
  endtask

  task automatic test_line();
    int hs_lo, first_lo_x, ls_cnt, act_cnt;
    bit prev_hs;
    hs_lo = 0; first_lo_x = -1; ls_cnt = 0; act_cnt = 0; prev_hs = vif_d.hsync;
    for (int i = 0; i < 800; i++) begin
      tick(1'b1, 1'b1, 1'b1);
      total++; if (obs_d() !== exp_d) begin bad++; $display("FAIL line_d: got %h want %h", obs_d(), exp_d); end
      total++; if (obs_a() !== exp_a) begin bad++; $display("FAIL line_a: got %h want %h", obs_a(), exp_a); end
      total++; if (obs_b() !== exp_b) begin bad++; $display("FAIL line_b: got %h want %h", obs_b(), exp_b); end
      if (!vif_d.hsync) hs_lo++;
      if (prev_hs && !vif_d.hsync && first_lo_x < 0) first_lo_x = int'(vif_d.x);
      prev_hs = vif_d.hsync;
      if (vif_d.line_start) ls_cnt++;
      if (vif_d.active) act_cnt++;
    end
    total++; if (hs_lo != 96) begin bad++; $display("FAIL line_hsync_width: got %0d want 96", hs_lo); end
    total++; if (first_lo_x != 656) begin bad++; $display("FAIL line_hsync_start: got %0d want 656", first_lo_x); end
    total++; if (ls_cnt != 1) begin bad++; $display("FAIL line_start_count: got %0d want 1", ls_cnt); end
    total++; if (act_cnt != 640) begin bad++; $display("FAIL line_active_count: got %0d want 640", act_cnt); end
  endtask

  task automatic test_frame();
    bit started, done;
    int span, vs_cnt, act_cnt;
    started = 1'b0; done = 1'b0; span = 0; vs_cnt = 0; act_cnt = 0;
    for (int i = 0; i < 1500 && !done; i++) begin
      tick(1'b1, 1'b1, 1'b1);
      total++; if (obs_a() !== exp_a) begin bad++; $display("FAIL frame_a: got %h want %h", obs_a(), exp_a); end
      total++; if (obs_b() !== exp_b) begin bad++; $display("FAIL frame_b: got %h want %h", obs_b(), exp_b); end
      if (vif_a.frame_start && started) begin
        done = 1'b1;
      end else begin
        if (vif_a.frame_start) begin
          started = 1'b1; span = 0; vs_cnt = 0; act_cnt = 0;
        end
        if (started) begin
          span++;
          if (!vif_a.vsync) vs_cnt++;
          if (vif_a.active) act_cnt++;
        end
      end
    end
    total++; if (!done) begin bad++; $display("FAIL frame_timeout: got no second frame_start want one within 1500 clk"); end
    total++; if (span != 425) begin bad++; $display("FAIL frame_period: got %0d want 425", span); end
    total++; if (vs_cnt != 50) begin bad++; $display("FAIL frame_vsync_width: got %0d want 50", vs_cnt); end
    total++; if (act_cnt != 160) begin bad++; $display("FAIL frame_active_count: got %0d want 160", act_cnt); end
  endtask

  task automatic test_enable_gap();
    int last_fs, interval, seen;
    bit ed, eb;
    last_fs = -1; interval = -1; seen = 0;
    for (int c = 0; c < 10000 && seen < 2; c++) begin
      ed = ($urandom_range(0, 3) == 0);
      eb = ($urandom_range(0, 2) == 0);
      tick(ed, (c % 10) == 0, eb);
      total++; if (obs_d() !== exp_d) begin bad++; $display("FAIL gap_d: got %h want %h", obs_d(), exp_d); end
      total++; if (obs_a() !== exp_a) begin bad++; $display("FAIL gap_a: got %h want %h", obs_a(), exp_a); end
      total++; if (obs_b() !== exp_b) begin bad++; $display("FAIL gap_b: got %h want %h", obs_b(), exp_b); end
      if (vif_a.frame_start) begin
        if (last_fs >= 0) interval = c - last_fs;
        last_fs = c;
        seen++;
      end
    end
    total++; if (interval != 4250) begin bad++; $display("FAIL gap_frame_interval: got %0d want 4250", interval); end
  endtask

  task automatic test_mid_reset();
    bit found;
    logic [24:0] park;
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      tick(1'b1, 1'b1, 1'b1);
      total++; if (obs_a() !== exp_a) begin bad++; $display("FAIL seek_a: got %h want %h", obs_a(), exp_a); end
      if (vif_a.x == 6'd20 && vif_a.y == 6'd12) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL mid_reset_seek: got no (20,12) want it within 600 clk"); end
    total++; if ({vif_a.hsync, vif_a.vsync} !== 2'b00) begin
      bad++; $display("FAIL mid_reset_syncs_on: got %b want 00", {vif_a.hsync, vif_a.vsync});
    end
    rst_n = 1'b0;
    #1;
    reset_models();
    park = {5'b11000, 10'd24, 10'd16};
    total++; if (obs_a() !== park) begin bad++; $display("FAIL mid_reset_a: got %h want %h", obs_a(), park); end
    total++; if (obs_d() !== exp_d) begin bad++; $display("FAIL mid_reset_d: got %h want %h", obs_d(), exp_d); end
    total++; if (obs_b() !== exp_b) begin bad++; $display("FAIL mid_reset_b: got %h want %h", obs_b(), exp_b); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1'b1, 1'b1, 1'b1);
    total++; if (obs_a() !== exp_a || !vif_a.frame_start) begin
      bad++; $display("FAIL post_reset_a: got %h want %h", obs_a(), exp_a);
    end
    total++; if (obs_d() !== exp_d) begin bad++; $display("FAIL post_reset_d: got %h want %h", obs_d(), exp_d); end
  endtask

  task automatic test_polarity();
    int hs_hi, rise_x, ls_cnt;
    bit prev_hs;
    hs_hi = 0; rise_x = -1; ls_cnt = 0; prev_hs = vif_b.hsync;
    for (int i = 0; i < 400; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      total++; if (obs_b() !== exp_b) begin bad++; $display("FAIL pol_b: got %h want %h", obs_b(), exp_b); end
      if (vif_b.hsync) hs_hi++;
      if (!prev_hs && vif_b.hsync) rise_x = int'(vif_b.x);
      prev_hs = vif_b.hsync;
      if (vif_b.line_start) ls_cnt++;
    end
    total++; if (hs_hi != 48) begin bad++; $display("FAIL pol_hsync_width: got %0d want 48", hs_hi); end
    total++; if (rise_x != 328) begin bad++; $display("FAIL pol_hsync_start: got %0d want 328", rise_x); end
    total++; if (ls_cnt != 1) begin bad++; $display("FAIL pol_line_length: got %0d line starts want 1 per 400", ls_cnt); end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_enable_gap();
    test_mid_reset();
    test_polarity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Video timing generator on the pixel-clock side of the clock tree.
- Consumes the PLL-derived clock plus a pixel-rate enable, and produces hsync/vsync, the active-video flag and pixel coordinates.
- Feeds the pattern generators and the output pins.
- Horizontal and vertical counters are fully parameterised; defaults are 640x480 standard timing.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (cycles, >=1)
- H_SYNC, 96, hsync pulse width (>=1)
- H_BP, 48, horizontal back porch (>=1)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines, >=1)
- V_SYNC, 2, vsync pulse width (>=1)
- V_BP, 33, vertical back porch (>=1)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- CW, 10, width of x/y counters; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  pixel-domain clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  pixel enable; counters and outputs advance only on cycles with en=1
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- active  out  1  high while (x,y) is inside the visible area
- x  out  CW  current horizontal position
- y  out  CW  current vertical position
- line_start  out  1  one-cycle pulse when x becomes 0
- frame_start  out  1  one-cycle pulse when (x,y) becomes (0,0)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (default 525).
- Counters hc and vc are registered and are driven directly on x and y.
- Reset (async assert, release synchronous to clk):
  - hc = H_TOTAL-1, vc = V_TOTAL-1.
  - hsync = !HS_POL, vsync = !VS_POL, active = 0, line_start = 0, frame_start = 0.
  - The first enabled cycle after reset therefore lands on (0,0).
- Advance rules, applied on rising clk with en=1:
  - If hc == H_TOTAL-1: hc <= 0.
    - If vc == V_TOTAL-1, vc <= 0; else vc <= vc+1.
  - Otherwise hc <= hc+1 and vc holds.
- en=0: all registers hold, including outputs; pulse outputs are forced to 0 on en=0 cycles.
- All outputs are registered and computed from the next counter values, so they describe exactly the (x,y) being presented. Latency from a counter update to its decoded outputs is 0 cycles; no output is combinational.
- Decoding at position (hc,vc):
  - active = (hc < H_ACTIVE) && (vc < V_ACTIVE).
  - hsync asserted for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (default 656..751).
  - vsync asserted for V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC (default 490..491), for whole lines including blanking columns.
  - line_start = 1 for exactly the enabled cycle where hc becomes 0.
  - frame_start = 1 only when hc and vc both become 0; line_start is also 1 on that cycle.
- Wrap-around: hc and vc never exceed H_TOTAL-1 and V_TOTAL-1; no intermediate out-of-range value appears.
- Reset mid-frame: counters jump immediately to (H_TOTAL-1, V_TOTAL-1) and outputs go to their reset values. Both sync pulses terminate at once.
- en held continuously high: one pixel per clk. en pulsed 1-in-N: one pixel per enable, with identical per-pixel output sequence.

Test Plan:
- Release reset with en=1 -> next edge gives x=0, y=0, active=1, line_start=1, frame_start=1, hsync=1, vsync=1 (default polarity).
- Run one line -> hsync=0 for exactly 96 enabled cycles starting at x=656. line_start recurs every 800 enabled cycles. active=1 for x=0..639 only.
- Run two frames -> frame_start pulses 420000 enabled cycles apart. vsync=0 for exactly 1600 enabled cycles (y=490..491). active count per frame = 307200.
- Drive en high 1 cycle in 10 -> x/y sequence identical to en=1 case. Outputs frozen and pulses 0 on en=0 cycles. frame_start interval = 4,200,000 clk.
- Assert rst_n low at x=700, y=491 (both syncs active) -> same cycle x=799, y=524, hsync=vsync=1, active=0. After release, first enabled edge -> (0,0) with frame_start=1.
- Instantiate with HS_POL=1, VS_POL=1, H_ACTIVE=320, H_FP=8, H_SYNC=48, H_BP=24 -> hsync high for x=328..375. Line length 400. Reset level of hsync/vsync = 0.
